// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM-like bus slave.
// Provides the FSM state type, transfer-size encodings, the default base
// address and the LFSR constants used when RANDOM_DELAY_EN is defined.
package sram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;

    // Wide enough for (15 - 1) + 3 extra random cycles.
    localparam int unsigned CNT_W = 5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci LFSR step, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // True for the three defined size encodings.
    function automatic logic size_legal(input logic [1:0] s);
        return (s == SIZE_BYTE) || (s == SIZE_HALF) || (s == SIZE_WORD);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Byte-lane-writable 32-bit storage array with combinational read.
// Ports: clk; we[3:0] per-byte write enables; widx/wdata write word index
// and data; ridx read word index; rdata combinational read data.
module sram_bank #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] widx,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] ridx,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write; contents are never cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/sram_like_slave.sv
// Memory-side responder for the CPU SRAM-like bus (req/addr_ok, data_ok).
// Accepts one request at a time and completes it LATENCY cycles after the
// accept edge with a one-cycle data_ok pulse.
// Ports: clk, reset (sync, active-high); req/wr/size/addr/wstrb/wdata from
// the master; addr_ok accept handshake; data_ok completion; rdata read data.
// Optional: define RANDOM_DELAY_EN to add 0..3 LFSR-chosen cycles of latency.
module sram_like_slave
    import sram_bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned        TAG_LSB  = ADDR_W + 2;
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [31-TAG_LSB:0] BASE_TAG = BASE_ADDR[31:TAG_LSB];

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic [31:0]      addr_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wdata_q;
    logic [1:0]       size_q;
    logic             addr_ok_q;
    logic             data_ok_q;
    logic [31:0]      rdata_q;

    logic [CNT_W-1:0] cnt_load_c;
    logic [ADDR_W-1:0] rd_idx_c;
    logic             rd_hit_c;
    logic             rd_wr_c;
    logic [31:0]      rd_val_c;
    logic             wr_hit_c;
    logic [3:0]       bank_we_c;
    logic [31:0]      bank_rdata;

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr_q;

    // Free-running LFSR; its two LSBs stretch the wait at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign cnt_load_c = CNT_INIT + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load_c = CNT_INIT;
`endif

    // Masked while reset is held so nothing is accepted in the reset cycle.
    assign addr_ok = addr_ok_q & ~reset;
    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

    // Read source: the incoming request when entering RESP straight from
    // IDLE, otherwise the latched request.
    assign rd_idx_c = (state_q == IDLE) ? addr[TAG_LSB-1:2] : addr_q[TAG_LSB-1:2];
    assign rd_hit_c = (state_q == IDLE) ? (addr[31:TAG_LSB] == BASE_TAG)
                                        : (addr_q[31:TAG_LSB] == BASE_TAG);
    assign rd_wr_c  = (state_q == IDLE) ? wr : wr_q;
    assign rd_val_c = (rd_hit_c && !rd_wr_c) ? bank_rdata : 32'h0;

    // Write commits at the end of RESP; out-of-range writes are dropped.
    assign wr_hit_c  = (addr_q[31:TAG_LSB] == BASE_TAG);
    assign bank_we_c = (state_q == RESP && wr_q && wr_hit_c && !reset) ? wstrb_q : 4'b0000;

    sram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we_c),
        .widx  (addr_q[TAG_LSB-1:2]),
        .wdata (wdata_q),
        .ridx  (rd_idx_c),
        .rdata (bank_rdata)
    );

    // Request FSM with registered handshake and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_ok_q <= 1'b1;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q      <= wr;
                        addr_q    <= addr;
                        wstrb_q   <= wstrb;
                        wdata_q   <= wdata;
                        size_q    <= size;
                        cnt_q     <= cnt_load_c;
                        addr_ok_q <= 1'b0;
                        if (cnt_load_c == '0) begin
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                            rdata_q   <= rd_val_c;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        rdata_q   <= rd_val_c;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    addr_ok_q <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    addr_ok_q <= 1'b1;
                end
            endcase
        end
    end

    // Size and byte offset are kept for debug visibility only.
    logic unused_ok;
    assign unused_ok = ^{size_q, addr_q[1:0], size_legal(size_q)};

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Memory-side responder for the CPU's SRAM-like bus: accepts one request at a time from the core's fetch or load/store port (req/addr_ok handshake) and returns completion (data_ok) after a parameterised latency.
- Sits below mycpu_top in the SoC-lite bench as the instruction or data memory model.
- Also serves as the reference slave for the upcoming multi-cycle/pipelined core bring-up.

Parameters:
- ADDR_W, 14, word-index width; storage depth is 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h1c000000, byte address of word 0; must be aligned to 4*2**ADDR_W.
- LATENCY, 1, cycles from an accepted request to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  1  master request valid.
- wr  in  1  1 = write, 0 = read; sampled with req.
- size  in  2  0 = byte, 1 = half, 2 = word; informational, latched for debug only.
- addr  in  32  byte address.
- wstrb  in  4  byte write strobes; ignored for reads.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid only while data_ok = 1 for a read.

Behaviour:
- Reset values: addr_ok 0 during the reset cycle, then 1 (IDLE); data_ok 0; rdata 0. Memory contents are not cleared.
- FSM states:
  - IDLE: addr_ok = 1. On req = 1, the request is accepted: latch wr, addr, wstrb, wdata, size; load cnt = LATENCY-1. Go to RESP if LATENCY = 1, else WAIT.
  - WAIT: addr_ok = 0. cnt decrements each cycle; when cnt = 1, go to RESP next cycle.
  - RESP: data_ok = 1 for exactly one cycle, addr_ok = 0, then return to IDLE.
- Latency: data_ok is asserted exactly LATENCY cycles after the accept edge.
- Accept throughput: at most one accept every LATENCY+1 cycles. A req held high across RESP is accepted again in the following IDLE cycle.
- Reads: rdata = mem[latched_addr index], where index = (addr - BASE_ADDR) >> 2. The read is performed from storage in the RESP cycle, so it reflects all previously completed writes.
- Writes: on the RESP cycle, byte lane i of the target word is updated with wdata[8i+7:8i] iff wstrb[i]. rdata = 0 for writes. wstrb = 0 is a legal no-op that still completes.
- Address decode: an address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W) is out of range. Such a request still completes with normal timing: reads return 32'h0, writes are dropped.
- Alignment: addr[1:0] is ignored for indexing. Lane selection is the master's responsibility via wstrb.
- Simultaneous events: req in WAIT or RESP is not accepted (addr_ok = 0); the master must hold req and its fields.
- Reset mid-operation: FSM goes to IDLE, any pending transaction is discarded (no data_ok, no write commit), and cnt is cleared.
- Inputs are ignored whenever req is low or addr_ok is low.

Optional Feature:
- Macro: RANDOM_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At accept, its two LSBs are added to the wait count, giving data_ok latency of LATENCY + {0..3} cycles.
  - All other rules are unchanged.
- Undefined: latency is fixed at LATENCY and no LFSR logic exists.

Decomposition:
- Shared package sram_bus_pkg:
  - FSM state typedef {IDLE, WAIT, RESP};
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD constants;
  - default BASE_ADDR;
  - LFSR seed and tap constants.
- One sub-module: sram_bank, a byte-lane-writable storage array (clk, we[3:0], widx, wdata, ridx, rdata, combinational read). sram_like_slave instantiates it.

Test Plan:
1. LATENCY=1: write addr 0x1c000010, wstrb 4'hF, wdata 32'hDEADBEEF, then read the same address. Required: each data_ok 1 cycle after its accept; read rdata = 32'hDEADBEEF.
2. Byte strobes: word 0x1c000020 holds 32'h11223344; write wstrb 4'b0101 with wdata 32'hAABBCCDD, then read. Required: rdata = 32'h11BB33DD.
3. LATENCY=4 with req held high continuously. Required: accepts at cycles 0, 5, 10; data_ok at cycles 4, 9, 14; addr_ok = 0 during WAIT and RESP.
4. Out of range: read addr 0x00000000. Required: data_ok after LATENCY cycles with rdata = 0. Write 32'h12345678 to BASE_ADDR + 4*2**ADDR_W. Required: a subsequent read of BASE_ADDR returns its prior contents unchanged.
5. Reset mid-operation: LATENCY=3, accept a write of 32'hCAFEF00D, assert reset 1 cycle later. Required: no data_ok; a later read of that address returns the old value; addr_ok = 1 in the first cycle after reset deasserts.
6. RANDOM_DELAY_EN defined, LATENCY=2, 200 back-to-back reads. Required: every latency is within 2..5, every value in 2..5 occurs at least once, and all data matches preloaded contents.
